// File: rtl/semaforo_pkg.sv
// Shared types for the semaforo_seq lamp driver: state codes, lamp patterns, directions.
// Optional max-green limit is enabled by defining SEMAFORO_MAXGREEN_EN.
package semaforo_pkg;

  typedef enum logic [2:0] {
    CLR_INIT = 3'd0,
    NS_G     = 3'd1,
    NS_Y     = 3'd2,
    NS_CLR   = 3'd3,
    LO_G     = 3'd4,
    LO_Y     = 3'd5,
    LO_CLR   = 3'd6
  } state_e;

  typedef enum logic {
    NS = 1'b0,
    LO = 1'b1
  } dir_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] lo;
  } lamps_t;

  // Anything not explicitly green or yellow shows red on both heads.
  function automatic lamps_t lamps_of(input state_e s);
    lamps_t l;
    case (s)
      NS_G:    begin l.ns = LAMP_G; l.lo = LAMP_R; end
      NS_Y:    begin l.ns = LAMP_Y; l.lo = LAMP_R; end
      LO_G:    begin l.ns = LAMP_R; l.lo = LAMP_G; end
      LO_Y:    begin l.ns = LAMP_R; l.lo = LAMP_Y; end
      default: begin l.ns = LAMP_R; l.lo = LAMP_R; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Loadable down-counter with tick enable and zero flag; holds at zero until reloaded.
module semaforo_timer #(
  parameter int            CW      = 4,
  parameter logic [CW-1:0] RST_VAL = {CW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Load wins over counting so a state entry always starts from a full dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (tick && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/semaforo_seq.sv
// Traffic-light lamp sequencer: green -> yellow -> all-red with tick-counted dwell times.
// Define SEMAFORO_MAXGREEN_EN to add the max-green starvation bound (second timer).
module semaforo_seq
  import semaforo_pkg::*;
#(
  parameter int T_GREEN_MIN = 4,
  parameter int T_YELLOW    = 2,
  parameter int T_CLEAR     = 1,
  parameter int T_GREEN_MAX = 12,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       N_S,
  input  logic       L_O,
  output logic [2:0] ns_lamp,
  output logic [2:0] lo_lamp,
  output logic [2:0] phase,
  output logic       busy
);

  localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_CLEAR  = CW'(T_CLEAR - 1);

  // Every dwell must be at least one tick and fit the counter.
  if ((T_GREEN_MIN < 1) || (T_YELLOW < 1) || (T_CLEAR < 1) || (T_GREEN_MAX < 1) ||
      ((T_GREEN_MIN - 1) >= (1 << CW)) || ((T_YELLOW - 1) >= (1 << CW)) ||
      ((T_CLEAR - 1) >= (1 << CW)) || ((T_GREEN_MAX - 1) >= (1 << CW))) begin : g_bad_timing
    $error("semaforo_seq: dwell parameters out of range for CW");
  end

  state_e        state_r;
  state_e        state_s;
  dir_e          last_r;
  dir_e          last_s;
  logic          load_s;
  logic [CW-1:0] load_val_s;
  logic [CW-1:0] cnt_s;
  logic          zero_s;
  logic          gmax_s;
  lamps_t        lamps_s;

  function automatic logic [CW-1:0] dwell(input state_e s);
    case (s)
      NS_G, LO_G: return LD_GREEN;
      NS_Y, LO_Y: return LD_YELLOW;
      default:    return LD_CLEAR;
    endcase
  endfunction

  semaforo_timer #(
    .CW      (CW),
    .RST_VAL (LD_CLEAR)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load_s),
    .load_val (load_val_s),
    .cnt      (cnt_s),
    .zero     (zero_s)
  );

`ifdef SEMAFORO_MAXGREEN_EN
  localparam logic [CW-1:0] LD_GMAX = CW'(T_GREEN_MAX - 1);
  logic          gload_s;
  logic [CW-1:0] gcnt_s;
  logic          gzero_s;

  assign gload_s = ((state_s == NS_G) && (state_r != NS_G)) ||
                   ((state_s == LO_G) && (state_r != LO_G));

  semaforo_timer #(
    .CW      (CW),
    .RST_VAL (LD_GMAX)
  ) u_gmax (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (gload_s),
    .load_val (LD_GMAX),
    .cnt      (gcnt_s),
    .zero     (gzero_s)
  );

  assign gmax_s = tick && gzero_s;
`else
  assign gmax_s = 1'b0;
`endif

  // State, direction memory and registered Moore outputs; all change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLR_INIT;
      last_r  <= LO;
      ns_lamp <= LAMP_R;
      lo_lamp <= LAMP_R;
      phase   <= 3'd0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      ns_lamp <= lamps_s.ns;
      lo_lamp <= lamps_s.lo;
      phase   <= state_s;
    end
  end

  // Next-state: exit rules are evaluated only on a tick with the dwell counter at zero.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      CLR_INIT, NS_CLR, LO_CLR: begin
        if (tick && zero_s) begin
          load_s = 1'b1;
          if (N_S && (!L_O || (last_r == LO))) begin
            state_s = NS_G;
          end else if (L_O) begin
            state_s = LO_G;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      NS_G: begin
        if (tick && (zero_s || gmax_s) && L_O) begin
          state_s = NS_Y;
          load_s  = 1'b1;
        end else begin
          state_s = NS_G;
        end
      end
      LO_G: begin
        if (tick && (zero_s || gmax_s) && N_S) begin
          state_s = LO_Y;
          load_s  = 1'b1;
        end else begin
          state_s = LO_G;
        end
      end
      NS_Y: begin
        if (tick && zero_s) begin
          state_s = NS_CLR;
          load_s  = 1'b1;
        end else begin
          state_s = NS_Y;
        end
      end
      LO_Y: begin
        if (tick && zero_s) begin
          state_s = LO_CLR;
          load_s  = 1'b1;
        end else begin
          state_s = LO_Y;
        end
      end
      default: begin
        state_s = CLR_INIT;
        load_s  = 1'b1;
      end
    endcase
  end

  // Output decode; busy follows the live requests, so it comes from the registered state.
  always_comb begin
    load_val_s = dwell(state_s);
    lamps_s    = lamps_of(state_s);
    last_s     = last_r;
    busy       = 1'b1;
    if ((state_s == NS_G) && (state_r != NS_G)) begin
      last_s = NS;
    end else if ((state_s == LO_G) && (state_r != LO_G)) begin
      last_s = LO;
    end else begin
      last_s = last_r;
    end
    case (state_r)
      NS_G:    busy = !((cnt_s == {CW{1'b0}}) && !L_O);
      LO_G:    busy = !((cnt_s == {CW{1'b0}}) && !N_S);
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_semaforo_seq.sv
// Directed self-checking bench for semaforo_seq (default build, max-green disabled).
module tb_semaforo_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       N_S;
  logic       L_O;
  logic [2:0] ns_lamp;
  logic [2:0] lo_lamp;
  logic [2:0] phase;
  logic       busy;

  int errors = 0;
  int checks = 0;

  semaforo_seq dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .N_S     (N_S),
    .L_O     (L_O),
    .ns_lamp (ns_lamp),
    .lo_lamp (lo_lamp),
    .phase   (phase),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_ns(input int ph);
    case (ph)
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_lo(input int ph);
    case (ph)
      4:       return 3'b001;
      5:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Phase, both heads from a phase-to-lamp table, and the never-both-non-red invariant.
  task automatic chk_state(input string tag, input int ph);
    logic [2:0] ph3;
    ph3 = ph[2:0];
    chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph3});
    chk({tag, ".ns_lamp"}, {5'd0, ns_lamp}, {5'd0, exp_ns(ph)});
    chk({tag, ".lo_lamp"}, {5'd0, lo_lamp}, {5'd0, exp_lo(ph)});
    chk({tag, ".invariant"}, {7'd0, (ns_lamp != 3'b100) && (lo_lamp != 3'b100)}, 8'd0);
  endtask

  int alt_ph [26] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 6,
                      1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5};

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    N_S  = 1'b0;
    L_O  = 1'b0;

    // Reset state
    step();
    chk_state("reset", 0);
    chk("reset.busy", {7'd0, busy}, 8'd1);

    // No requests: stays in clearance
    rst  = 1'b0;
    tick = 1'b1;
    step();
    step();
    chk_state("idle", 0);
    chk("idle.busy", {7'd0, busy}, 8'd1);

    // Single N_S request: NS_G after one tick, then rests with busy low
    N_S = 1'b1;
    step();
    chk_state("single.entry", 1);
    chk("single.entry.busy", {7'd0, busy}, 8'd1);
    step();
    step();
    step();
    chk_state("single.rest", 1);
    chk("single.rest.busy", {7'd0, busy}, 8'd0);
    step();
    step();
    chk_state("single.rest2", 1);
    chk("single.rest2.busy", {7'd0, busy}, 8'd0);

    // Asynchronous reset between edges
    rst = 1'b1;
    #2;
    chk_state("async_rst", 0);
    step();
    rst = 1'b0;
    N_S = 1'b1;
    L_O = 1'b0;

    // Conflict handover with a tick freeze inside NS_Y
    step();
    chk_state("hand.g1", 1);
    step();
    L_O = 1'b1;
    chk_state("hand.g2", 1);
    step();
    chk_state("hand.g3", 1);
    step();
    chk_state("hand.g4", 1);
    chk("hand.g4.busy", {7'd0, busy}, 8'd1);
    step();
    chk_state("hand.y1", 2);
    tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
    end
    chk_state("freeze", 2);
    tick = 1'b1;
    step();
    chk_state("hand.y2", 2);
    step();
    chk_state("hand.clr", 3);
    step();
    chk_state("hand.lo_g", 4);

    // Alternation with both requests from reset (last=LO at reset, so NS first)
    rst = 1'b1;
    #1;
    rst = 1'b0;
    N_S = 1'b1;
    L_O = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step();
      chk_state($sformatf("alt[%0d]", i), alt_ph[i]);
    end

    // Reset while in LO_Y, then L_O alone
    rst = 1'b1;
    #1;
    chk_state("rst_yellow", 0);
    step();
    rst = 1'b0;
    N_S = 1'b0;
    L_O = 1'b1;
    step();
    chk_state("after_rst.lo_g", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
